// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the L1 data cache controller: address geometry, FSM states,
// tag entry layout and address field helpers.
package cache_ctrl_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned INDEX_W  = 8;
    localparam int unsigned OFFSET_W = 4;
    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        StIdle,
        StCompare,
        StWriteback,
        StAllocate
    } cache_state_e;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } cache_tag_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                    input logic [INDEX_W-1:0] index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_ctrl.sv
// Sequencing controller for the direct-mapped write-back, write-allocate L1 data cache.
// Handles one CPU access at a time, running write-back and line fill on misses.
module cache_ctrl
    import cache_ctrl_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cpu_req_valid_i,
    output logic                 cpu_req_ready_o,
    input  logic                 cpu_we_i,
    input  logic [ADDR_W-1:0]    cpu_addr_i,
    output logic                 cpu_resp_valid_o,
    input  logic [TAG_W+1:0]     tag_rd_i,
    output logic                 tag_wr_en_o,
    output logic [TAG_W+1:0]     tag_wr_o,
    output logic [INDEX_W-1:0]   index_o,
    output logic                 data_word_we_o,
    output logic                 data_line_we_o,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    output logic                 mem_we_o,
    output logic [ADDR_W-1:0]    mem_addr_o
);

    cache_state_e      state_q, state_d;
    logic              req_we_q, req_we_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;

    cache_tag_t        resident;
    cache_tag_t        tag_wr;
    logic [TAG_W-1:0]  req_tag;
    logic              hit;

    assign resident = cache_tag_t'(tag_rd_i);
    assign req_tag  = addr_tag(req_addr_q);
    assign index_o  = addr_index(req_addr_q);
    assign hit      = resident.valid && (resident.tag == req_tag);
    assign tag_wr_o = tag_wr;

    always_comb begin
        state_d          = state_q;
        req_we_d         = req_we_q;
        req_addr_d       = req_addr_q;
        cpu_req_ready_o  = 1'b0;
        cpu_resp_valid_o = 1'b0;
        tag_wr_en_o      = 1'b0;
        tag_wr           = '0;
        data_word_we_o   = 1'b0;
        data_line_we_o   = 1'b0;
        mem_req_valid_o  = 1'b0;
        mem_we_o         = 1'b0;
        mem_addr_o       = '0;

        unique case (state_q)
            StIdle: begin
                cpu_req_ready_o = 1'b1;
                if (cpu_req_valid_i) begin
                    req_we_d   = cpu_we_i;
                    req_addr_d = cpu_addr_i;
                    state_d    = StCompare;
                end
            end
            StCompare: begin
                if (hit) begin
                    cpu_resp_valid_o = 1'b1;
                    if (req_we_q) begin
                        data_word_we_o = 1'b1;
                        tag_wr_en_o    = 1'b1;
                        tag_wr         = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
                    end
                    state_d = StIdle;
                end else if (resident.valid && resident.dirty) begin
                    // An invalid line never needs write-back, whatever its dirty bit says.
                    state_d = StWriteback;
                end else begin
                    state_d = StAllocate;
                end
            end
            StWriteback: begin
                // Index is held, so the resident tag read stays stable for the whole wait.
                mem_req_valid_o = 1'b1;
                mem_we_o        = 1'b1;
                mem_addr_o      = line_addr(resident.tag, index_o);
                if (mem_req_ready_i) begin
                    state_d = StAllocate;
                end
            end
            StAllocate: begin
                mem_req_valid_o = 1'b1;
                mem_addr_o      = line_addr(req_tag, index_o);
                if (mem_req_ready_i) begin
                    data_line_we_o = 1'b1;
                    tag_wr_en_o    = 1'b1;
                    tag_wr         = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
                    state_d        = StCompare;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            req_we_q   <= 1'b0;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            req_we_q   <= req_we_d;
            req_addr_q <= req_addr_d;
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: stimulus queues expected events, a negedge monitor
// pops and compares them as the controller produces them.
module tb_cache_ctrl;

    localparam int KMem  = 0;
    localparam int KTag  = 1;
    localparam int KResp = 2;

    typedef struct {
        int          kind;
        logic [63:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cpu_req_valid_i = 1'b0;
    logic        cpu_req_ready_o;
    logic        cpu_we_i = 1'b0;
    logic [31:0] cpu_addr_i = '0;
    logic        cpu_resp_valid_o;
    logic [21:0] tag_rd_i;
    logic        tag_wr_en_o;
    logic [21:0] tag_wr_o;
    logic [7:0]  index_o;
    logic        data_word_we_o;
    logic        data_line_we_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;

    logic [21:0] tag_mem [256] = '{default: '0};
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [21:0] pre_val = '0;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass = 0;
    int  cyc = 0;
    int  last_resp_cyc = -1;
    int  accept_cyc = 0;
    int  hs_cyc = 0;

    cache_ctrl dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .cpu_req_valid_i  (cpu_req_valid_i),
        .cpu_req_ready_o  (cpu_req_ready_o),
        .cpu_we_i         (cpu_we_i),
        .cpu_addr_i       (cpu_addr_i),
        .cpu_resp_valid_o (cpu_resp_valid_o),
        .tag_rd_i         (tag_rd_i),
        .tag_wr_en_o      (tag_wr_en_o),
        .tag_wr_o         (tag_wr_o),
        .index_o          (index_o),
        .data_word_we_o   (data_word_we_o),
        .data_line_we_o   (data_line_we_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Tag memory model: asynchronous read, write on the clock edge.
    assign tag_rd_i = tag_mem[index_o];
    always @(posedge clk) begin
        if (pre_we) tag_mem[pre_idx] <= pre_val;
        else if (tag_wr_en_o) tag_mem[index_o] <= tag_wr_o;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic exp_mem(input logic we, input logic [31:0] addr);
        exp_q.push_back('{kind: KMem, val: {31'b0, we, addr}});
    endtask

    task automatic exp_tag(input logic v, input logic d, input logic [19:0] tag,
                           input logic word, input logic line);
        exp_q.push_back('{kind: KTag, val: {39'b0, 1'b1, v, d, tag, word, line}});
    endtask

    task automatic exp_resp();
        exp_q.push_back('{kind: KResp, val: 64'd0});
    endtask

    task automatic observe(input int kind, input logic [63:0] val);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind %0d val 0x%0h expected none (t=%0t)",
                     kind, val, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.val === val) n_pass++;
            else $display("FAIL event: got kind %0d val 0x%0h expected kind %0d val 0x%0h (t=%0t)",
                          kind, val, e.kind, e.val, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_ni) begin
            if (mem_req_valid_o && mem_req_ready_i)
                observe(KMem, {31'b0, mem_we_o, mem_addr_o});
            if (tag_wr_en_o || data_word_we_o || data_line_we_o)
                observe(KTag, {39'b0, tag_wr_en_o, tag_wr_o, data_word_we_o, data_line_we_o});
            if (cpu_resp_valid_o) begin
                observe(KResp, 64'd0);
                last_resp_cyc = cyc;
            end
        end
    end

    task automatic cpu_req(input logic we, input logic [31:0] addr);
        @(posedge clk); #1;
        cpu_req_valid_i = 1'b1;
        cpu_we_i        = we;
        cpu_addr_i      = addr;
        accept_cyc      = cyc;
        @(posedge clk); #1;
        cpu_req_valid_i = 1'b0;
    endtask

    // Waits for a memory request, holds ready low for 'delay' cycles checking stability.
    task automatic mem_serve(input int delay);
        int          n = 0;
        logic [31:0] a0;
        logic        w0;
        @(negedge clk);
        while (!mem_req_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!mem_req_valid_o) begin
            chk("mem_req_timeout", 64'd0, 64'd1);
            return;
        end
        a0 = mem_addr_o;
        w0 = mem_we_o;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("wait_valid_held", {63'b0, mem_req_valid_o}, 64'd1);
            chk("wait_addr_held", {32'b0, mem_addr_o}, {32'b0, a0});
            chk("wait_we_held", {63'b0, mem_we_o}, {63'b0, w0});
            chk("wait_cpu_ready_low", {63'b0, cpu_req_ready_o}, 64'd0);
        end
        @(posedge clk); #1;
        mem_req_ready_i = 1'b1;
        hs_cyc = cyc;
        @(posedge clk); #1;
        mem_req_ready_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!cpu_req_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_idle", {63'b0, cpu_req_ready_o}, 64'd1);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        // Stale dirty bit on an invalid line at index 2.
        pre_we  = 1'b1;
        pre_idx = 8'd2;
        pre_val = {1'b0, 1'b1, 20'hABCDE};
        repeat (2) @(posedge clk);
        #1 pre_we = 1'b0;

        @(negedge clk);
        chk("rst_cpu_ready", {63'b0, cpu_req_ready_o}, 64'd1);
        chk("rst_mem_valid", {63'b0, mem_req_valid_o}, 64'd0);
        chk("rst_resp", {63'b0, cpu_resp_valid_o}, 64'd0);
        chk("rst_tag_wr_en", {63'b0, tag_wr_en_o}, 64'd0);
        chk("rst_index", {56'b0, index_o}, 64'd0);
        chk("rst_mem_addr", {32'b0, mem_addr_o}, 64'd0);
        @(posedge clk); #1 rst_ni = 1'b1;

        // Cold load: clean miss, fill, re-compare hit.
        exp_mem(1'b0, 32'h0000_1000);
        exp_tag(1'b1, 1'b0, 20'h00001, 1'b0, 1'b1);
        exp_resp();
        cpu_req(1'b0, 32'h0000_1000);
        mem_serve(0);
        wait_idle();
        chk("cold_resp_cycle", 64'(last_resp_cyc), 64'(hs_cyc + 1));

        // Stray ready while idle must be ignored.
        @(posedge clk); #1 mem_req_ready_i = 1'b1;
        @(negedge clk);
        chk("stray_ready_idle", {63'b0, cpu_req_ready_o}, 64'd1);
        @(posedge clk); #1 mem_req_ready_i = 1'b0;

        // Load hit.
        exp_resp();
        cpu_req(1'b0, 32'h0000_1004);
        wait_idle();
        chk("hit_load_latency", 64'(last_resp_cyc), 64'(accept_cyc + 1));

        // Store hit marks the line dirty.
        exp_tag(1'b1, 1'b1, 20'h00001, 1'b1, 1'b0);
        exp_resp();
        cpu_req(1'b1, 32'h0000_1008);
        wait_idle();
        chk("hit_store_latency", 64'(last_resp_cyc), 64'(accept_cyc + 1));

        // Dirty conflict miss at index 0: write-back then fill.
        exp_mem(1'b1, 32'h0000_1000);
        exp_mem(1'b0, 32'h0001_1000);
        exp_tag(1'b1, 1'b0, 20'h00011, 1'b0, 1'b1);
        exp_resp();
        cpu_req(1'b0, 32'h0001_1000);
        mem_serve(0);
        mem_serve(0);
        wait_idle();
        chk("final_tag_idx0", {42'b0, tag_mem[0]}, {42'b0, 1'b1, 1'b0, 20'h00011});

        // Store miss with a 5-cycle memory stall.
        exp_mem(1'b0, 32'h0000_2010);
        exp_tag(1'b1, 1'b0, 20'h00002, 1'b0, 1'b1);
        exp_tag(1'b1, 1'b1, 20'h00002, 1'b1, 1'b0);
        exp_resp();
        cpu_req(1'b1, 32'h0000_2014);
        mem_serve(5);
        wait_idle();

        // Invalid line with stale dirty bit goes straight to fill.
        exp_mem(1'b0, 32'h0000_3020);
        exp_tag(1'b1, 1'b0, 20'h00003, 1'b0, 1'b1);
        exp_resp();
        cpu_req(1'b0, 32'h0000_3024);
        mem_serve(0);
        wait_idle();

        // Reset during write-back of dirty index 1.
        cpu_req(1'b0, 32'h0000_5010);
        begin
            int n = 0;
            @(negedge clk);
            while (!mem_req_valid_o && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("wb_valid", {63'b0, mem_req_valid_o}, 64'd1);
        chk("wb_we", {63'b0, mem_we_o}, 64'd1);
        chk("wb_addr", {32'b0, mem_addr_o}, 64'h0000_2010);
        @(posedge clk); #3 rst_ni = 1'b0;
        #1;
        chk("async_rst_mem_valid", {63'b0, mem_req_valid_o}, 64'd0);
        chk("async_rst_cpu_ready", {63'b0, cpu_req_ready_o}, 64'd1);
        @(posedge clk); #1 rst_ni = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {63'b0, cpu_req_ready_o}, 64'd1);
        chk("post_rst_queue", 64'(exp_q.size()), 64'd0);

        // Controller works normally after the aborted transaction.
        exp_resp();
        cpu_req(1'b0, 32'h0001_1004);
        wait_idle();
        chk("post_rst_hit_latency", 64'(last_resp_cyc), 64'(accept_cyc + 1));

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
